// File: rtl/bicubic_out_serializer.sv
// bicubic_out_serializer
// Captures the four interpolated pixels presented on each active cycle as one
// FIFO entry and replays them one pixel per transfer on a valid/ready stream,
// lane 0 first. The interpolator cannot be stalled, so a write arriving while
// the FIFO is full (and no entry is leaving) is dropped and flagged.
// Optional feature macro: BICUBIC_SER_DROPCNT_EN enables the saturating
// 16-bit dropped-entry counter on drop_cnt; otherwise drop_cnt is tied to 0.
module bicubic_out_serializer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              act,
    input  logic [DATA_W-1:0] in_0,
    input  logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] in_2,
    input  logic [DATA_W-1:0] in_3,
    output logic [DATA_W-1:0] out_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    localparam int ENTRY_W = 4 * DATA_W;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_C  = (AW + 1)'(0);

    // Entry storage; deliberately not reset
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    lane_q,   lane_d;
    logic [AW:0]   count_q,  count_d;
    logic          overflow_q, overflow_d;

    logic          valid_s;
    logic          transfer_s;
    logic          pop_s;
    logic          wr_en_s;
    logic          drop_s;
    logic [ENTRY_W-1:0] entry_s;

    // Handshake decode: transfers, pops, accepted writes and dropped writes
    always_comb begin
        valid_s    = (count_q != ZERO_C);
        transfer_s = valid_s && out_ready;
        pop_s      = transfer_s && (lane_q == 2'd3);
        wr_en_s    = act && ((count_q < DEPTH_C) || pop_s);
        drop_s     = act && !wr_en_s;
    end

    // Next-state computation for pointers, lane, occupancy and the sticky flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_d     = lane_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        // lane is 2 bits wide, so 3 -> 0 on a pop comes for free
        if (transfer_s) begin
            lane_d = lane_q + 2'd1;
        end else begin
            lane_d = lane_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (drop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            lane_q     <= 2'd0;
            count_q    <= ZERO_C;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry write port; lane 0 lands in the least significant field
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= {in_3, in_2, in_1, in_0};
        end
    end

    // First-word fall-through pixel select; forced to zero while empty
    always_comb begin
        entry_s = mem_q[rd_ptr_q];
        out_pix = {DATA_W{1'b0}};
        if (valid_s) begin
            case (lane_q)
                2'd0:    out_pix = entry_s[0*DATA_W +: DATA_W];
                2'd1:    out_pix = entry_s[1*DATA_W +: DATA_W];
                2'd2:    out_pix = entry_s[2*DATA_W +: DATA_W];
                2'd3:    out_pix = entry_s[3*DATA_W +: DATA_W];
                default: out_pix = {DATA_W{1'b0}};
            endcase
        end else begin
            out_pix = {DATA_W{1'b0}};
        end
    end

    assign out_valid = valid_s;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == ZERO_C);
    assign overflow  = overflow_q;

`ifdef BICUBIC_SER_DROPCNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped entries
    always_comb begin
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Dropped-entry counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_bicubic_out_serializer.sv
// Directed self-checking bench for bicubic_out_serializer.
module tb_bicubic_out_serializer;

    logic       clk;
    logic       rst;
    logic       act;
    logic [7:0] in_0, in_1, in_2, in_3;
    logic [7:0] out_pix;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [15:0] drop_cnt;

    int checks;
    int errors;

`ifdef BICUBIC_SER_DROPCNT_EN
    localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
    localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

    bicubic_out_serializer #(.DATA_W(8), .DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .act       (act),
        .in_0      (in_0),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int b);
        in_0 = 8'(b);
        in_1 = 8'(b + 1);
        in_2 = 8'(b + 2);
        in_3 = 8'(b + 3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        act = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; act = 1'b1; out_ready = 1'b0;
        set_lanes(1);
        step(); step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
        rst = 1'b0;
        step();
        act = 1'b0;
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL reset_first_write_count: got %0d expected 1", count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_write_valid: got %0b expected 1", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_pix !== 8'(i + 1)) begin errors++; $display("FAIL reset_drain_pix%0d: got %0d expected %0d", i, out_pix, i + 1); end
            step();
        end
        out_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_drain_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_single();
        do_reset();
        act = 1'b1; out_ready = 1'b1;
        set_lanes(10);
        step();
        act = 1'b0;
        set_lanes(99);
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid%0d: got %0b expected 1", i, out_valid); end
            checks++; if (out_pix !== 8'(10 + i)) begin errors++; $display("FAIL single_pix%0d: got %0d expected %0d", i, out_pix, 10 + i); end
            step();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end: got %0b expected 0", out_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count_end: got %0d expected 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx;
        logic [7:0] held;
        do_reset();
        act = 1'b1;
        set_lanes(1); step();
        set_lanes(5); step();
        act = 1'b0;
        idx = 1;
        for (int c = 0; c < 40 && idx <= 8; c++) begin
            out_ready = (c % 2 == 0);
            held = out_pix;
            if (out_ready && out_valid) begin
                checks++; if (out_pix !== 8'(idx)) begin errors++; $display("FAIL bp_pix: got %0d expected %0d", out_pix, idx); end
                idx++;
                step();
            end else begin
                step();
                checks++; if (out_pix !== held) begin errors++; $display("FAIL bp_hold: got %0d expected %0d", out_pix, held); end
            end
        end
        out_ready = 1'b0;
        checks++; if (idx !== 9) begin errors++; $display("FAIL bp_count: got %0d expected 9", idx); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL bp_empty: got %0b expected 1", empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        act = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            set_lanes(k);
            step();
        end
        act = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %0b expected 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        checks++; if (drop_cnt !== EXP_DROP1) begin errors++; $display("FAIL ovf_dropcnt: got %0d expected %0d", drop_cnt, EXP_DROP1); end
        out_ready = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            for (int l = 0; l < 4; l++) begin
                checks++; if (out_pix !== 8'(e + l)) begin errors++; $display("FAIL ovf_drain e%0d l%0d: got %0d expected %0d", e, l, out_pix, e + l); end
                step();
            end
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_no_entry9: got %0b expected 0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_full_simultaneous();
        do_reset();
        act = 1'b1;
        for (int e = 0; e < 8; e++) begin
            set_lanes(4 * e);
            step();
        end
        act = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL sim_full: got %0b expected 1", full); end
        out_ready = 1'b1;
        for (int l = 0; l < 3; l++) begin
            checks++; if (out_pix !== 8'(l)) begin errors++; $display("FAIL sim_pre%0d: got %0d expected %0d", l, out_pix, l); end
            step();
        end
        checks++; if (out_pix !== 8'd3) begin errors++; $display("FAIL sim_lane3: got %0d expected 3", out_pix); end
        act = 1'b1;
        set_lanes(200);
        step();
        act = 1'b0;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL sim_count: got %0d expected 8", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf: got %0b expected 0", overflow); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL sim_drop: got %0d expected 0", drop_cnt); end
        for (int p = 4; p < 32; p++) begin
            checks++; if (out_pix !== 8'(p)) begin errors++; $display("FAIL sim_old p%0d: got %0d expected %0d", p, out_pix, p); end
            step();
        end
        for (int l = 0; l < 4; l++) begin
            checks++; if (out_pix !== 8'(200 + l)) begin errors++; $display("FAIL sim_new%0d: got %0d expected %0d", l, out_pix, 200 + l); end
            step();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_empty: got %0b expected 1", empty); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int got;
        do_reset();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            act = (c < 80) && (c % 4 == 0);
            set_lanes(c);
            if (out_valid) begin
                checks++; if (out_pix !== 8'(got)) begin errors++; $display("FAIL wrap_pix: got %0d expected %0d", out_pix, got); end
                got++;
            end
            step();
        end
        act = 1'b0;
        checks++; if (got !== 80) begin errors++; $display("FAIL wrap_total: got %0d expected 80", got); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf: got %0b expected 0", overflow); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        act = 1'b0;
        out_ready = 1'b0;
        set_lanes(0);
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_full_simultaneous();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bicubic_out_serializer.md
Name: bicubic_out_serializer

Overview:
- Downstream stage of the bicubic interpolator. Captures the four 8-bit interpolated pixels (out_0..out_3) that the interpolator presents on each active cycle.
- Buffers them as 4-pixel entries in a small FIFO.
- Emits them one pixel per transfer on an 8-bit valid/ready stream towards the frame writer.
- The interpolator has no backpressure, so the block absorbs bursts and flags any loss.

Parameters:
- DATA_W, 8: pixel width in bits.
- DEPTH, 8: FIFO entries, each holding 4 pixels. Must be a power of 2, minimum 2.
- AW, 3: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- act  in  1  input valid; the interpolator outputs are meaningful this cycle.
- in_0  in  DATA_W  pixel lane 0 (interpolator out_0).
- in_1  in  DATA_W  pixel lane 1 (interpolator out_1).
- in_2  in  DATA_W  pixel lane 2 (interpolator out_2).
- in_3  in  DATA_W  pixel lane 3 (interpolator out_3).
- out_pix  out  DATA_W  serialized pixel.
- out_valid  out  1  out_pix holds valid data.
- out_ready  in  1  downstream accepts out_pix this cycle.
- count  out  AW+1  number of occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when a write is dropped.
- drop_cnt  out  16  number of dropped entries (optional feature only).

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, lane=0, count=0, overflow=0, drop_cnt=0.
  - Outputs during reset: out_valid=0, empty=1, full=0. out_pix is don't-care; it is driven by 0 while empty.
  - Memory contents are not reset.
- Write:
  - Condition: act=1 AND (count<DEPTH OR pop occurs this cycle).
  - Action: mem[wr_ptr] <= {in_3,in_2,in_1,in_0}, then wr_ptr+1.
  - wr_ptr wraps modulo DEPTH.
- Transfer: occurs when out_valid=1 AND out_ready=1.
  - lane increments 0 to 1 to 2 to 3.
  - A transfer with lane=3 is a pop: lane returns to 0 and rd_ptr increments, wrapping modulo DEPTH.
- Read path:
  - out_valid = (count != 0).
  - out_pix = lane field (lane*DATA_W +: DATA_W) of mem[rd_ptr], selected combinationally (first-word fall-through).
  - Lane order is in_0 first, in_3 last.
- Latency: an entry written on edge k gives out_valid=1 immediately after edge k, provided the FIFO was empty before edge k. Throughput is 1 pixel per cycle while out_ready=1.
- count updates:
  - +1 on write without pop.
  - -1 on pop without write.
  - Unchanged on simultaneous write and pop, including when full.
- Dropped write: act=1 while full with no pop.
  - Entry is discarded; pointers are unchanged.
  - overflow <= 1 and stays 1 until rst.
- out_ready=0: lane and rd_ptr hold, and out_pix stays stable.
- Write into an empty FIFO never bypasses within the same cycle; out_valid rises on the following cycle.
- act=0: no write, regardless of the in_* values.
- rst asserted mid-stream: partially serialized entry and all buffered data are discarded; the block restarts from the reset state.

Optional Feature:
- Macro: BICUBIC_SER_DROPCNT_EN.
- Defined:
  - drop_cnt is a 16-bit counter, incremented on each dropped write.
  - It saturates at 16'hFFFF and is cleared by rst.
- Undefined:
  - drop_cnt is tied to 16'd0; no counter logic is synthesized.
  - overflow behaviour is identical in both cases.

Test Plan:
- Reset check: rst=1 with act=1 and in_0..3 = 1,2,3,4 -> no write, count=0, empty=1, out_valid=0. Release rst -> first write on the next edge.
- Single entry, out_ready=1: act pulse with in_0..3 = 10,11,12,13 -> out_pix 10,11,12,13 on 4 consecutive cycles, then out_valid=0, count back to 0.
- Backpressure: 2 entries (1..4, 5..8), out_ready toggled 1,0,1,0 -> sequence 1..8 is delivered in order with no repeats or skips, and out_pix is held while out_ready=0.
- Full and overflow: out_ready=0, act high for 9 cycles with lanes k,k+1,k+2,k+3 for k=1..9 -> count=8, full=1, overflow=1, drop_cnt=1 (macro on). Drain -> entries 1..8 output; entry 9 is never output.
- Simultaneous write and pop when full: count=8, lane=3 transfer and act=1 in the same cycle -> count stays 8, no drop, overflow stays 0, new entry is output last.
- Wrap-around: 20 act cycles interleaved with continuous draining (out_ready=1, act every 4th cycle) -> all 80 pixels in order, pointers wrap past 7, overflow=0.
